add_sched: RTL and testbench
============================

# add_sched

Round-robin scheduler that shares one 16-bit dual-sum conditional adder between NREQ requesters. It supports multi-word (multi-precision) additions by locking the adder to one requester for a burst and chaining the carry between words. It sits in front of the shared adder, which exposes a 34-bit value: [33] carry-out for cin=1, [32] carry-out for cin=0, [31:16] sum for cin=0, [15:0] sum for cin=1. Results return on a single valid/ready response channel tagged with the requester ID.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, $clog2(NREQ), response ID width
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester beat valid
- req_ready  out  NREQ  per-requester accept (at most one bit set)
- req_a  in  NREQ*16  operand A, requester i at [16i+15:16i]
- req_b  in  NREQ*16  operand B, same packing
- req_cin  in  NREQ  carry-in, used on the first word of a burst only
- req_last  in  NREQ  1 = final word of burst
- add_a  out  16  operand A driven to the shared adder
- add_b  out  16  operand B driven to the shared adder
- add_value  in  34  adder result in the 34-bit format above
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  IDW  requester index of the response
- rsp_sum  out  16  selected sum
- rsp_cout  out  1  selected carry-out
- rsp_last  out  1  copy of req_last for this beat
- stat_beats  out  32  accepted beats (only with ADD_SCHED_STATS_EN)
- stat_stalls  out  32  stall-cycle count (only with ADD_SCHED_STATS_EN)

## Operation
- State: lock (0/1), owner[IDW-1:0], carry (1b), rr_ptr[IDW-1:0], response register.
- Grant g:
  - lock=1: g=owner, granted only if req_valid[owner].
  - lock=0: first valid requester scanning rr_ptr, rr_ptr+1, … mod NREQ.
- can_accept = !rsp_valid | rsp_ready. req_ready[g] = req_valid[g] & can_accept; all other bits are 0.
- add_a/add_b = req_a/req_b of g when there is a grant, else 0. Driven combinationally because the adder is combinational.
- Effective cin = lock ? carry : req_cin[g].
- Result selection: sum = cin ? add_value[15:0] : add_value[31:16]; cout = cin ? add_value[33] : add_value[32].
- On accept:
  - Load the response register with {g, sum, cout, req_last[g]} and set rsp_valid.
  - carry <= cout.
  - If req_last[g]=0: lock<=1, owner<=g.
  - If req_last[g]=1: lock<=0, carry<=0, rr_ptr<=(g+1) mod NREQ.
- Without an accept: if rsp_ready, clear rsp_valid. Otherwise the response register holds stable.
- A locked owner that drops req_valid mid-burst keeps the lock. No other requester is granted; the cycles are bubbles.
- A single-word transaction (last=1 on the first beat) never sets lock.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_last=0, add_a=0, add_b=0.
  - lock=0, carry=0, rr_ptr=0, stats=0.
- Latency: a beat accepted in cycle N is presented on rsp_* in cycle N+1.
- Throughput: 1 beat/cycle while rsp_ready=1.
- Backpressure:
  - rsp_valid & !rsp_ready forces req_ready=0 and holds the response.
  - Simultaneous rsp_ready and accept replaces the response with no bubble.
- Reset asserted mid-burst drops the lock and the pending response. Carry and rr_ptr return to 0.
- Arbitration changes only at burst boundaries.

## Configuration
- ADD_SCHED_STATS_EN defined:
  - stat_beats increments on each accept.
  - stat_stalls increments on each cycle with any req_valid set and no accept.
  - Both are 32-bit and wrap at 2^32.
- ADD_SCHED_STATS_EN undefined: the stat ports and counters are absent; all other behaviour is identical.

## Test plan
- Single add: req0 a=0xFFFF, b=0x0001, cin=0, last=1 → next cycle rsp_id=0, sum=0x0000, cout=1, last=1.
- Carry chain: req1 beat0 a=0xFFFF, b=0x0001, cin=0, last=0; beat1 a=0x0000, b=0x0000, last=1 → responses sum=0x0000/cout=1, then sum=0x0001/cout=0. req2 valid throughout gets no grant until after beat1.
- Round-robin: all four requesters valid with single-word beats, from reset → grant order 0,1,2,3,0.
- Backpressure: rsp_ready=0 for 3 cycles with a response pending → rsp_* stable, req_ready=0, no beat lost; then rsp_ready=1 → one response per cycle resumes.
- Reset mid-burst: req3 sends last=0, then rst_n=0 for one cycle → rsp_valid=0, lock cleared. The next req0 beat with cin=0 uses carry-in 0 and is granted first.
- Stats (with ADD_SCHED_STATS_EN): 5 accepts and 2 backpressure cycles with valid held → stat_beats=5, stat_stalls=2.

Source files
------------

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler sharing one external 16-bit dual-sum
// conditional adder between NREQ requesters. It supports multi-word bursts:
// the adder stays locked to one requester and the carry is chained between
// words.
//
// Adder result format (add_value):
//   [33]    carry-out for cin=1
//   [32]    carry-out for cin=0
//   [31:16] sum for cin=0
//   [15:0]  sum for cin=1
//
// Optional macro ADD_SCHED_STATS_EN adds the stat_beats/stat_stalls counters.
//
// Scheduler state (no enumerated FSM; the lock bit is the only mode):
//   lock | meaning
//   0    | idle or between bursts, round-robin arbitration from rr_ptr
//   1    | mid-burst, adder held for owner, carry chained from last word
module add_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*16-1:0]   req_a,
   input  logic [NREQ*16-1:0]   req_b,
   input  logic [NREQ-1:0]      req_cin,
   input  logic [NREQ-1:0]      req_last,
   output logic [15:0]          add_a,
   output logic [15:0]          add_b,
   input  logic [33:0]          add_value,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [15:0]          rsp_sum,
   output logic                 rsp_cout,
   output logic                 rsp_last
`ifdef ADD_SCHED_STATS_EN
   ,
   output logic [31:0]          stat_beats,
   output logic [31:0]          stat_stalls
`endif
);

   logic            lock;
   logic [IDW-1:0]  owner;
   logic            carry;
   logic [IDW-1:0]  rr_ptr;

   logic            gnt_valid;
   logic [IDW-1:0]  gnt_idx;
   logic [IDW-1:0]  cand_idx;
   int              cand;

   logic [15:0]     a_sel;
   logic [15:0]     b_sel;
   logic            cin_sel;
   logic            last_sel;

   logic            can_accept;
   logic            accept;
   logic            eff_cin;
   logic [15:0]     sum_sel;
   logic            cout_sel;
   logic [IDW-1:0]  nxt_ptr;

   // Grant selection: locked owner wins outright, otherwise first valid from rr_ptr.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      if (lock) begin
         gnt_idx   = owner;
         gnt_valid = req_valid[owner];
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            cand     = (int'(rr_ptr) + i) % NREQ;
            cand_idx = cand[IDW-1:0];
            if (!gnt_valid && req_valid[cand_idx]) begin
               gnt_valid = 1'b1;
               gnt_idx   = cand_idx;
            end
         end
      end
   end

   // Operand and control mux for the granted requester.
   always_comb begin
      a_sel    = '0;
      b_sel    = '0;
      cin_sel  = 1'b0;
      last_sel = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            a_sel    = req_a[16*i +: 16];
            b_sel    = req_b[16*i +: 16];
            cin_sel  = req_cin[i];
            last_sel = req_last[i];
         end
      end
   end

   // Handshake, adder drive and result selection. Gated by rst_n so nothing
   // is offered or accepted while reset is held.
   always_comb begin
      can_accept = !rsp_valid || rsp_ready;
      accept     = gnt_valid && can_accept && rst_n;
      req_ready  = '0;
      if (accept)
         req_ready[gnt_idx] = 1'b1;
      add_a    = (gnt_valid && rst_n) ? a_sel : 16'h0000;
      add_b    = (gnt_valid && rst_n) ? b_sel : 16'h0000;
      eff_cin  = lock ? carry : cin_sel;
      sum_sel  = eff_cin ? add_value[15:0] : add_value[31:16];
      cout_sel = eff_cin ? add_value[33]   : add_value[32];
      nxt_ptr  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
   end

   // Response register, burst lock, carry chain and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock      <= 1'b0;
         owner     <= '0;
         carry     <= 1'b0;
         rr_ptr    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         rsp_cout  <= 1'b0;
         rsp_last  <= 1'b0;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rsp_id    <= gnt_idx;
         rsp_sum   <= sum_sel;
         rsp_cout  <= cout_sel;
         rsp_last  <= last_sel;
         if (last_sel) begin
            lock   <= 1'b0;
            carry  <= 1'b0;
            rr_ptr <= nxt_ptr;
         end else begin
            lock   <= 1'b1;
            owner  <= gnt_idx;
            carry  <= cout_sel;
         end
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

`ifdef ADD_SCHED_STATS_EN
   // Beat and stall counters; both wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat_beats  <= '0;
         stat_stalls <= '0;
      end else begin
         if (accept)
            stat_beats <= stat_beats + 32'd1;
         if ((|req_valid) && !accept)
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_add_sched.sv
// Directed testbench for add_sched (NREQ=4). Models the shared dual-sum
// adder combinationally and checks each step with immediate assertions.
// Stats checks are compiled in when ADD_SCHED_STATS_EN is defined.
module tb_add_sched;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*16-1:0]   req_a;
   logic [NREQ*16-1:0]   req_b;
   logic [NREQ-1:0]      req_cin;
   logic [NREQ-1:0]      req_last;
   logic [15:0]          add_a;
   logic [15:0]          add_b;
   logic [33:0]          add_value;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [15:0]          rsp_sum;
   logic                 rsp_cout;
   logic                 rsp_last;
`ifdef ADD_SCHED_STATS_EN
   logic [31:0]          stat_beats;
   logic [31:0]          stat_stalls;
`endif

   int checks = 0;
   int errors = 0;

   logic [16:0] sum0;
   logic [16:0] sum1;

   assign sum0      = {1'b0, add_a} + {1'b0, add_b};
   assign sum1      = {1'b0, add_a} + {1'b0, add_b} + 17'd1;
   assign add_value = {sum1[16], sum0[16], sum0[15:0], sum1[15:0]};

   add_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_cin     (req_cin),
      .req_last    (req_last),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_value   (add_value),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_sum     (rsp_sum),
      .rsp_cout    (rsp_cout),
      .rsp_last    (rsp_last)
`ifdef ADD_SCHED_STATS_EN
      ,
      .stat_beats  (stat_beats),
      .stat_stalls (stat_stalls)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic [15:0] a,
                          input logic [15:0] b, input logic cin, input logic last);
      req_valid[i]      = v;
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_cin[i]        = cin;
      req_last[i]       = last;
   endtask

   task automatic chk_rsp(input string tag, input logic [IDW-1:0] id, input logic [15:0] sum,
                          input logic cout, input logic last);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_id"},    32'(rsp_id),    32'(id));
      chk({tag, "_sum"},   32'(rsp_sum),   32'(sum));
      chk({tag, "_cout"},  32'(rsp_cout),  32'(cout));
      chk({tag, "_last"},  32'(rsp_last),  32'(last));
   endtask

   initial begin
      logic [1:0]  exp_id;
      logic [15:0] exp_sum;

      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      req_last  = '0;
      tick();
      tick();

      // Reset values; a request held during reset must not be offered.
      set_req(0, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id",    32'(rsp_id),    32'd0);
      chk("rst_rsp_sum",   32'(rsp_sum),   32'd0);
      chk("rst_rsp_cout",  32'(rsp_cout),  32'd0);
      chk("rst_rsp_last",  32'(rsp_last),  32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_add_a",     32'(add_a),     32'd0);
      chk("rst_add_b",     32'(add_b),     32'd0);

      // Single add: 0xFFFF + 0x0001, cin=0.
      rst_n = 1'b1;
      #1;
      chk("single_ready", 32'(req_ready), 32'h1);
      chk("single_add_a", 32'(add_a),     32'hFFFF);
      chk("single_add_b", 32'(add_b),     32'h0001);
      tick();
      set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      chk_rsp("single", 2'd0, 16'h0000, 1'b1, 1'b1);
      tick();
      chk("single_drain", 32'(rsp_valid), 32'd0);

      // Carry chain on req1 (rr_ptr is now 1) with req2 waiting.
      set_req(1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      set_req(2, 1'b1, 16'h1234, 16'h0001, 1'b0, 1'b1);
      #1;
      chk("chain_b0_ready", 32'(req_ready), 32'h2);
      tick();
      chk_rsp("chain_b0", 2'd1, 16'h0000, 1'b1, 1'b0);
      // Owner drops valid mid-burst: bubble, req2 still locked out.
      set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      #1;
      chk("chain_bubble_ready", 32'(req_ready), 32'h0);
      tick();
      chk("chain_bubble_rsp", 32'(rsp_valid), 32'd0);
      set_req(1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
      #1;
      chk("chain_b1_ready", 32'(req_ready), 32'h2);
      tick();
      chk_rsp("chain_b1", 2'd1, 16'h0001, 1'b0, 1'b1);
      set_req(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      #1;
      chk("chain_req2_ready", 32'(req_ready), 32'h4);
      tick();
      chk_rsp("chain_req2", 2'd2, 16'h1235, 1'b0, 1'b1);
      set_req(2, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
      chk("chain_drain", 32'(rsp_valid), 32'd0);

      // Round-robin from reset, all four valid with single-word beats.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++)
         set_req(i, 1'b1, 16'(16'h1000 * (i + 1)), 16'h0001, i[0], 1'b1);
      for (int k = 0; k < 5; k++) begin
         exp_id  = 2'(k % 4);
         exp_sum = 16'(16'h1000 * (int'(exp_id) + 1) + 1 + int'(exp_id[0]));
         #1;
         chk("rr_ready", 32'(req_ready), 32'(1 << exp_id));
         tick();
         chk_rsp("rr", exp_id, exp_sum, 1'b0, 1'b1);
      end

      // Backpressure: response id0 held for three cycles.
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'h0);
         tick();
         chk_rsp("bp_hold", 2'd0, 16'h1001, 1'b0, 1'b1);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_resume_ready", 32'(req_ready), 32'h2);
      tick();
      chk_rsp("bp_resume1", 2'd1, 16'h2002, 1'b0, 1'b1);
      tick();
      chk_rsp("bp_resume2", 2'd2, 16'h3001, 1'b0, 1'b1);
      req_valid = '0;
`ifdef ADD_SCHED_STATS_EN
      chk("stat_beats",  stat_beats,  32'd7);
      chk("stat_stalls", stat_stalls, 32'd3);
`endif
      tick();
      chk("bp_drain", 32'(rsp_valid), 32'd0);

      // Reset mid-burst on req3 (rr_ptr is now 3).
      set_req(3, 1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0);
      #1;
      chk("mid_ready", 32'(req_ready), 32'h8);
      tick();
      chk_rsp("mid_b0", 2'd3, 16'h0001, 1'b1, 1'b0);
      rst_n = 1'b0;
      set_req(3, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
      chk("mid_rst_rsp", 32'(rsp_valid), 32'd0);
      rst_n = 1'b1;
      set_req(0, 1'b1, 16'h0005, 16'h0003, 1'b0, 1'b1);
      set_req(3, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1);
      #1;
      chk("post_rst_ready0", 32'(req_ready), 32'h1);
      tick();
      chk_rsp("post_rst_r0", 2'd0, 16'h0008, 1'b0, 1'b1);
      set_req(0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      #1;
      chk("post_rst_ready3", 32'(req_ready), 32'h8);
      tick();
      chk_rsp("post_rst_r3", 2'd3, 16'h0000, 1'b0, 1'b1);
      req_valid = '0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
